// File: rtl/tick_receiver.sv
// Recovers a one-cycle tick per rising edge of a slow asynchronous clock and
// measures the edge spacing. It also flags a stalled input clock.
module tick_receiver #(
    parameter int CNT_W      = 12,
    parameter int TIMEOUT    = 4095,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk_rx,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lost,
    output logic [7:0]       edge_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);

    state_t state_q, state_d;

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             lost_q, lost_d;
    logic [7:0]       edge_q, edge_d;

    logic rise;
    logic acc;
    logic loss;

    // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3 (history for edge detection)
    assign sync_d = {sync_q[1:0], clk_in};
    assign rise   = sync_q[1] & ~sync_q[2];

    // The spacing check only applies once a first edge has been seen.
    assign acc  = en & rise & ((state_q == IDLE) | (cnt_q >= MIN_C));
    assign loss = en & (state_q != IDLE) & (cnt_q == TIMEOUT_C) & ~acc;

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (acc) state_d = ARMED;
                ARMED:   if (acc) state_d = LOCKED;
                         else if (loss) state_d = IDLE;
                LOCKED:  if (loss) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_d   = acc;
        period_d = period_q;
        pv_d     = pv_q;
        lost_d   = lost_q;
        edge_d   = edge_q + 8'(acc);
        cnt_d    = cnt_q;
        if (!en) begin
            cnt_d  = '0;
            pv_d   = 1'b0;
            lost_d = 1'b0;
        end else begin
            if (acc) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q < TIMEOUT_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (acc && state_q != IDLE) begin
                period_d = cnt_q;
                pv_d     = 1'b1;
            end else if (loss) begin
                pv_d = 1'b0;
            end
            if (acc) begin
                lost_d = 1'b0;
            end else if (loss) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            lost_q   <= 1'b0;
            edge_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            lost_q   <= lost_d;
            edge_q   <= edge_d;
        end
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign lost         = lost_q;
    assign edge_cnt     = edge_q;

endmodule

// File: tb/tb_tick_receiver.sv
// Scoreboard bench for tick_receiver: each expected-accepted clk_in rise
// queues its tick record; the monitor checks every tick against the queue.
module tb_tick_receiver;

    localparam int CNT_W      = 12;
    localparam int TIMEOUT    = 300;
    localparam int MIN_PERIOD = 4;

    logic             clk_rx;
    logic             rst;
    logic             clk_in;
    logic             en;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             lost;
    logic [7:0]       edge_cnt;

    tick_receiver #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk_rx(clk_rx), .rst(rst), .clk_in(clk_in), .en(en),
        .tick(tick), .period(period), .period_valid(period_valid),
        .lost(lost), .edge_cnt(edge_cnt)
    );

    initial clk_rx = 1'b0;
    always #5 clk_rx = ~clk_rx;

    int cyc = 0;
    always @(posedge clk_rx) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int per;
        int pv;
        int ec;
    } exp_t;

    exp_t q[$];
    int   n_tot = 0;
    int   n_bad = 0;

    // stimulus-side model of what the next accepted edge should report
    bit   have_prev;
    int   prev_c;
    int   last_per;
    int   exp_edges;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic model_clear();
        have_prev = 1'b0;
    endtask

    // drive a rise that must be accepted; tick lands 3 edges later
    task automatic rise_acc();
        exp_t e;
        clk_in = 1'b1;
        e.cyc = cyc + 3;
        e.per = have_prev ? (cyc - prev_c) : last_per;
        e.pv  = have_prev ? 1 : 0;
        exp_edges = (exp_edges + 1) & 255;
        e.ec  = exp_edges;
        q.push_back(e);
        last_per  = e.per;
        have_prev = 1'b1;
        prev_c    = cyc;
    endtask

    task automatic train(input int n);
        for (int i = 0; i < n; i++) begin
            rise_acc();
            tk(4);
            clk_in = 1'b0;
            tk(4);
        end
    endtask

    always @(negedge clk_rx) begin : mon
        exp_t e;
        if (tick === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_tick", 32'(tick), 32'd0);
            end else begin
                e = q.pop_front();
                chk("tick_cyc", cyc, e.cyc);
                chk("tick_period", 32'(period), e.per);
                chk("tick_pv", 32'(period_valid), e.pv);
                chk("tick_edge_cnt", 32'(edge_cnt), e.ec);
                chk("tick_lost", 32'(lost), 32'd0);
            end
        end
    end

    initial begin : stim
        int target;
        rst = 1'b1;
        en = 1'b1;
        clk_in = 1'b0;
        have_prev = 1'b0;
        prev_c = 0;
        last_per = 0;
        exp_edges = 0;
        tk(3);
        rst = 1'b0;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_pv", 32'(period_valid), 0);
        chk("rst_lost", 32'(lost), 0);
        chk("rst_edge_cnt", 32'(edge_cnt), 0);
        tk(2);

        // steady period-8 clock: lock
        train(4);
        chk("lock_pv", 32'(period_valid), 1);

        // real rise with a short high phase, then a glitch 2 cycles later
        rise_acc();
        tk(1);
        clk_in = 1'b0;
        tk(1);
        clk_in = 1'b1;
        tk(1);
        clk_in = 1'b0;
        tk(3);
        chk("glitch_period", 32'(period), 8);
        tk(2);
        train(2);

        // stall clk_in low until loss
        target = prev_c + 3 + TIMEOUT - 1;
        tk(target - cyc);
        chk("pre_loss_lost", 32'(lost), 0);
        chk("pre_loss_pv", 32'(period_valid), 1);
        tk(1);
        chk("loss_lost", 32'(lost), 1);
        chk("loss_pv", 32'(period_valid), 0);
        chk("loss_period", 32'(period), 8);
        model_clear();
        tk(5);
        chk("loss_sticky", 32'(lost), 1);
        train(3);

        // drop en for 10 cycles with clk_in held high
        rise_acc();
        tk(5);
        en = 1'b0;
        tk(1);
        chk("en0_pv", 32'(period_valid), 0);
        chk("en0_lost", 32'(lost), 0);
        chk("en0_period", 32'(period), 8);
        model_clear();
        tk(9);
        en = 1'b1;
        tk(5);
        clk_in = 1'b0;
        tk(4);
        train(2);

        // reset pulse mid-period while locked
        rise_acc();
        tk(4);
        clk_in = 1'b0;
        tk(2);
        rst = 1'b1;
        tk(1);
        rst = 1'b0;
        chk("mrst_tick", 32'(tick), 0);
        chk("mrst_period", 32'(period), 0);
        chk("mrst_pv", 32'(period_valid), 0);
        chk("mrst_lost", 32'(lost), 0);
        chk("mrst_edge_cnt", 32'(edge_cnt), 0);
        model_clear();
        last_per = 0;
        exp_edges = 0;
        tk(1);
        train(2);

        // run to 260 accepted edges since reset
        train(258);
        chk("wrap_edge_cnt", 32'(edge_cnt), 4);

        tk(10);
        chk("pending_ticks", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
